// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: issues word fetches under a credit limit and queues responses for decode.
// Optional same-cycle response bypass to decode is enabled with FETCH_BYPASS_EN.
module fetch_buffer #(
    parameter int                         ADDRESS_WIDTH = 32,
    parameter int                         DATA_WIDTH    = 32,
    parameter int                         DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     req_valid,
    output logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic                     req_ready,
    input  logic                     resp_valid,
    input  logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_V = (CW+1)'(DEPTH);

    typedef enum logic {FETCH, FLUSH} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic [ADDRESS_WIDTH-1:0] buf_pc   [DEPTH];
    logic [DATA_WIDTH-1:0]    buf_data [DEPTH];
    logic [ADDRESS_WIDTH-1:0] fly_pc   [DEPTH];
    logic [PW-1:0]            head, tail, fly_head, fly_tail;
    logic [CW-1:0]            occ, outstanding, discard_cnt;

    logic                     req_fire, resp_keep, resp_drop;
    logic                     bypass, push, pop;
    logic [CW:0]              pend;
    logic [CW-1:0]            left, flush_left;
    logic [DATA_WIDTH-1:0]    head_data;
    logic [ADDRESS_WIDTH-1:0] head_pc;

    assign pend      = {1'b0, occ} + {1'b0, outstanding};
    assign req_valid = !rst && !redirect && (state == FETCH)
                       && (pend < DEPTH_V);
    assign req_addr  = fetch_pc;
    assign req_fire  = req_valid && req_ready;

    // Responses are only kept in FETCH; anything else is stale or spurious
    assign resp_keep = !rst && !redirect && (state == FETCH)
                       && resp_valid && (outstanding != '0);
    assign resp_drop = (state == FLUSH) && resp_valid
                       && (discard_cnt != '0);

`ifdef FETCH_BYPASS_EN
    assign bypass    = resp_keep && (occ == '0);
    assign head_data = (occ == '0) ? resp_data : buf_data[head];
    assign head_pc   = (occ == '0) ? fly_pc[fly_head] : buf_pc[head];
`else
    assign bypass    = 1'b0;
    assign head_data = buf_data[head];
    assign head_pc   = buf_pc[head];
`endif

    assign instr_valid = !rst && !redirect && ((occ != '0) || bypass);
    assign instr       = instr_valid ? head_data : '0;
    assign instr_pc    = instr_valid ? head_pc : '0;

    assign pop  = instr_valid && instr_ready && (occ != '0);
    assign push = resp_keep && !(bypass && instr_ready);

    // Responses still owed by memory once this cycle's response is counted
    assign left       = outstanding + discard_cnt;
    assign flush_left = left - CW'(resp_valid && (left != '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            occ         <= '0;
            outstanding <= '0;
            discard_cnt <= '0;
            head        <= '0;
            tail        <= '0;
            fly_head    <= '0;
            fly_tail    <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc & ~ADDRESS_WIDTH'(3);
            occ         <= '0;
            outstanding <= '0;
            head        <= '0;
            tail        <= '0;
            fly_head    <= '0;
            fly_tail    <= '0;
            discard_cnt <= flush_left;
            state       <= (flush_left != '0) ? FLUSH : FETCH;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + ADDRESS_WIDTH'(4);
                fly_tail <= fly_tail + 1'b1;
            end
            if (resp_keep)
                fly_head <= fly_head + 1'b1;
            if (push)
                tail <= tail + 1'b1;
            if (pop)
                head <= head + 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_keep);
            occ         <= occ + CW'(push) - CW'(pop);
            if (state == FLUSH) begin
                if (resp_drop)
                    discard_cnt <= discard_cnt - 1'b1;
                if ((discard_cnt == '0) || (discard_cnt == CW'(1) && resp_valid))
                    state <= FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            fly_pc[fly_tail] <= fetch_pc;
        if (push) begin
            buf_pc[tail]   <= fly_pc[fly_head];
            buf_data[tail] <= resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: 1-cycle memory model plus a scoreboard of
// expected decode-side instructions; set FETCH_BYPASS_EN to match the RTL build.
module tb_fetch_buffer;

    localparam int          DEPTH = 4;
    localparam logic [31:0] MAGIC = 32'h00500093;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    fetch_buffer #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_data(resp_data),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready),
        .redirect(redirect),
        .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        exp_q[$];
    logic [31:0] mem_q[$];
    int          total = 0;
    int          bad = 0;
    int          tb_out = 0;
    int          tb_disc = 0;
    int          acc = 0;
    int          pops = 0;
    logic [31:0] tb_pc = '0;
    logic [31:0] first_pop_pc = '0;
    bit          hold = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic tick(input bit rr, input bit ir, input bit rd,
                        input logic [31:0] rpc);
        bit          keep, exp_rv, exp_iv, fire, took_new;
        logic [31:0] raddr, faddr;
        ent_t        e;
        req_ready   = rr;
        instr_ready = ir;
        redirect    = rd;
        redirect_pc = rpc;
        raddr       = (mem_q.size() > 0) ? mem_q[0] : 32'h0;
        resp_valid  = !hold && (mem_q.size() > 0);
        resp_data   = resp_valid ? (raddr ^ MAGIC) : 32'h0;
        #1;
        keep   = !rd && resp_valid && tb_disc == 0 && tb_out > 0;
        exp_rv = !rd && tb_disc == 0 && (exp_q.size() + tb_out < DEPTH);
        chk("req_valid", req_valid, exp_rv);
        fire  = req_valid && rr;
        faddr = req_addr;
        if (fire) begin
            chk("req_addr", req_addr, tb_pc);
            tb_pc += 4;
            acc++;
        end
        exp_iv = !rd && (exp_q.size() > 0 || (BYP && keep));
        chk("instr_valid", instr_valid, exp_iv);
        took_new = 1'b0;
        if (exp_iv && ir) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e = '{pc: raddr, data: raddr ^ MAGIC};
                took_new = 1'b1;
            end
            chk("instr", instr, e.data);
            chk("instr_pc", instr_pc, e.pc);
            if (pops == 0) first_pop_pc = e.pc;
            pops++;
        end
        if (resp_valid) void'(mem_q.pop_front());
        if (rd) begin
            tb_disc = tb_disc + tb_out
                      - ((resp_valid && (tb_disc + tb_out) > 0) ? 1 : 0);
            tb_out = 0;
            exp_q.delete();
            tb_pc = rpc & ~32'h3;
        end else if (resp_valid) begin
            if (tb_disc > 0) begin
                tb_disc--;
            end else if (tb_out > 0) begin
                tb_out--;
                if (!took_new)
                    exp_q.push_back('{pc: raddr, data: raddr ^ MAGIC});
            end
        end
        if (fire) tb_out++;
        @(posedge clk);
        if (fire) mem_q.push_back(faddr);
        @(negedge clk);
    endtask

    // Hold reset over two falling edges while a junk response is offered.
    task automatic do_reset();
        rst = 1'b1;
        mem_q.delete();
        exp_q.delete();
        tb_out = 0;
        tb_disc = 0;
        tb_pc = 32'h0;
        hold = 1'b0;
        req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect = 1'b0;
        resp_valid = 1'b1;
        resp_data = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        resp_valid = 1'b0;
        resp_data = 32'h0;
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_req_addr", req_addr, 0);
        @(negedge clk);
        do_reset();

        // Streaming with ready memory and decode
        pops = 0;
        repeat (12) tick(1, 1, 0, 32'h0);
        chk("stream_pops", pops, BYP ? 11 : 10);
        chk("stream_first_pc", first_pop_pc, 32'h0);

        // Decode stalled: credit limit caps requests at DEPTH
        do_reset();
        acc = 0;
        repeat (8) tick(1, 0, 0, 32'h0);
        chk("credit_acc", acc, DEPTH);
        pops = 0;
        repeat (6) tick(1, 1, 0, 32'h0);
        chk("credit_drain", pops >= 4, 1);
        chk("credit_first_pc", first_pop_pc, 32'h0);

        // Redirect with three requests outstanding
        do_reset();
        hold = 1'b1;
        acc = 0;
        repeat (3) tick(1, 1, 0, 32'h0);
        chk("redir_acc", acc, 3);
        tick(1, 1, 1, 32'h103);
        hold = 1'b0;
        pops = 0;
        repeat (3) tick(1, 1, 0, 32'h0);
        chk("redir_drops", acc, 3);
        repeat (6) tick(1, 1, 0, 32'h0);
        chk("redir_resume", acc > 3, 1);
        chk("redir_first_pc", first_pop_pc, 32'h100);

        // Redirect coincident with response and instr_ready
        do_reset();
        pops = 0;
        acc = 0;
        tick(1, 0, 0, 32'h0);
        tick(0, 0, 0, 32'h0);
        tick(1, 0, 0, 32'h0);
        tick(1, 1, 1, 32'h200);
        chk("same_cyc_no_pop", pops, 0);
        tick(1, 1, 0, 32'h0);
        chk("same_cyc_resume", acc, 3);
        repeat (5) tick(1, 1, 0, 32'h0);
        chk("same_cyc_first_pc", first_pop_pc, 32'h200);

        // Asynchronous reset in the middle of a burst
        repeat (5) tick(1, 1, 0, 32'h0);
        req_ready = 1'b1;
        instr_ready = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_req_valid", req_valid, 0);
        chk("async_instr_valid", instr_valid, 0);
        chk("async_instr", instr, 0);
        chk("async_instr_pc", instr_pc, 0);
        chk("async_req_addr", req_addr, 0);
        @(negedge clk);
        do_reset();
        pops = 0;
        repeat (8) tick(1, 1, 0, 32'h0);
        chk("async_first_pc", first_pop_pc, 32'h0);
        chk("async_pops", pops, BYP ? 7 : 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
FETCH_BUFFER -- requirements
Module: fetch_buffer

Interface
REQ-001 Parameters: ADDRESS_WIDTH, default 32, PC/address width; DATA_WIDTH, default 32, instruction width; DEPTH, default 4, buffer entries (power of two, >=2); RESET_PC, default 0, first fetch address.
REQ-002 Ports: clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  output  1  fetch request to instruction memory.
REQ-005 req_addr  output  ADDRESS_WIDTH  word-aligned fetch address.
REQ-006 req_ready  input  1  memory accepts request.
REQ-007 resp_valid  input  1  instruction word returning, in request order, at least 1 cycle after acceptance.
REQ-008 resp_data  input  DATA_WIDTH  returned instruction.
REQ-009 instr_valid  output  1  buffer head valid for decode.
REQ-010 instr  output  DATA_WIDTH  head instruction.
REQ-011 instr_pc  output  ADDRESS_WIDTH  address of head instruction.
REQ-012 instr_ready  input  1  decode consumes head.
REQ-013 redirect  input  1  taken branch/jump; flush and refetch.
REQ-014 redirect_pc  input  ADDRESS_WIDTH  new fetch address; bits [1:0] ignored, treated as 0.

Function
REQ-015 Handshakes: request transfers when req_valid && req_ready; instruction transfers when instr_valid && instr_ready; req_addr stable while req_valid high and not accepted, except on redirect.
REQ-016 fetch_pc increments by 4 per accepted request, wrapping modulo 2^ADDRESS_WIDTH.
REQ-017 Credit rule: req_valid high only in state FETCH and when occupancy + outstanding < DEPTH; buffer never overflows.
REQ-018 Each accepted address pushed into an in-flight address queue; each kept response pops it and writes {address, resp_data} into buffer tail.
REQ-019 Simultaneous push and pop on a full or empty buffer both legal; occupancy unchanged when both occur.
REQ-020 FSM states: FETCH (normal), FLUSH (discarding stale responses).
REQ-021 redirect in any state: buffer and in-flight queue cleared, fetch_pc <= redirect_pc & ~3, discard_cnt <= outstanding after this cycle's transfers; next state FLUSH if that count > 0, else FETCH.
REQ-022 On the redirect cycle: req_valid low, instr_valid low, any same-cycle response counted as discarded, any same-cycle instr_ready ignored.
REQ-023 FLUSH: req_valid low; each resp_valid decrements discard_cnt and is dropped; transition to FETCH in the cycle discard_cnt reaches 0 (first request next cycle).
REQ-024 resp_valid with zero outstanding is ignored.
REQ-025 Default latency: response written at clock edge, instr_valid high next cycle (1 cycle response-to-decode).

Reset
REQ-026 While rst high: state FETCH, fetch_pc = RESET_PC, occupancy, outstanding, discard_cnt = 0; req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0.
REQ-027 First request (req_addr = RESET_PC) asserted in first cycle after rst deasserts; reset mid-operation abandons all in-flight responses without error.

Configuration
REQ-028 Macro FETCH_BYPASS_EN: when defined, a kept response arriving while buffer empty drives instr/instr_pc/instr_valid combinationally in the same cycle; if instr_ready also high it is consumed and not written; otherwise written as normal.
REQ-029 Without FETCH_BYPASS_EN: no combinational path resp_* to instr_*; latency per REQ-025.

Verification
REQ-030 Reset release, req_ready=1, 1-cycle memory, instr_ready=1 -> req_addr 0x0,0x4,0x8...; instr_pc sequence 0x0,0x4,0x8 with matching data, no gaps after fill.
REQ-031 instr_ready=0, DEPTH=4 -> exactly 4 requests accepted, req_valid low thereafter; raise instr_ready -> 4 instructions in order, fetch resumes at 0x10.
REQ-032 3 requests outstanding, redirect with redirect_pc=0x103 -> next 3 responses dropped, first new request 0x100 after 3rd drop, instr_pc first shows 0x100.
REQ-033 redirect same cycle as resp_valid and instr_ready, 1 outstanding -> response dropped, head not consumed downstream, FETCH resumes next cycle.
REQ-034 rst asserted asynchronously mid-burst -> outputs zero immediately; after release req_addr = RESET_PC, stale responses absent from instr.
REQ-035 With FETCH_BYPASS_EN, empty buffer, resp_valid with data 0x00500093 -> instr=0x00500093 and instr_valid=1 same cycle; without macro -> next cycle.
